// File: rtl/fb_triple_buffer_scheduler_if.sv
// Bus between the triple-buffer scheduler and its camera-writer / VGA-reader clients.
// The master drives the frame events and vsync; the slave (scheduler) returns bank selection.
interface fb_triple_buffer_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  i_cam_frame_start;
  logic                  i_cam_frame_done;
  logic                  i_vga_vsync;
  logic                  o_wr_allow;
  logic [1:0]            o_wr_bank;
  logic [1:0]            o_rd_bank;
  logic [ADDR_WIDTH-1:0] o_wr_base;
  logic [ADDR_WIDTH-1:0] o_rd_base;
  logic                  o_frame_ready;
  logic                  o_swap;
  logic [CNT_WIDTH-1:0]  o_drop_cnt;
  logic [CNT_WIDTH-1:0]  o_abort_cnt;

  modport master (
    output i_cam_frame_start, i_cam_frame_done, i_vga_vsync,
    input  o_wr_allow, o_wr_bank, o_rd_bank, o_wr_base, o_rd_base,
    input  o_frame_ready, o_swap, o_drop_cnt, o_abort_cnt
  );

  modport slave (
    input  i_cam_frame_start, i_cam_frame_done, i_vga_vsync,
    output o_wr_allow, o_wr_bank, o_rd_bank, o_wr_base, o_rd_base,
    output o_frame_ready, o_swap, o_drop_cnt, o_abort_cnt
  );
endinterface

// File: rtl/fb_triple_buffer_scheduler.sv
// Triple-buffer bank scheduler: camera writes a free bank, display flips to the newest
// complete frame only at the leading edge of vsync, so frames never tear.
module fb_triple_buffer_scheduler #(
  parameter int unsigned ADDR_WIDTH       = 18,
  parameter int unsigned DEPTH            = 76_800,
  parameter int unsigned CNT_WIDTH        = 16,
  parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  fb_triple_buffer_scheduler_if.slave bus
);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] BASE_1 = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_2 = ADDR_WIDTH'(2 * DEPTH);

  logic [1:0]            state, state_nx;
  logic [1:0]            rd_bank, rd_nx, wr_bank, wr_nx, rdy_bank, rdy_nx;
  logic                  rdy_valid, valid_nx;
  logic                  vsync_q, vsync_act, vsync_edge;
  logic                  swap_q, swap_nx;
  logic                  wr_allow_q;
  logic [ADDR_WIDTH-1:0] wr_base_q, rd_base_q;
  logic [CNT_WIDTH-1:0]  drop_cnt, drop_nx, abort_cnt, abort_nx;
  logic                  publish;

  // Constant bank-to-base select keeps the address path free of a multiplier.
  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [1:0] bank);
    case (bank)
      2'd1:    base_of = BASE_1;
      2'd2:    base_of = BASE_2;
      default: base_of = '0;
    endcase
  endfunction

  assign vsync_act  = (VSYNC_ACTIVE_LOW != 0) ? ~bus.i_vga_vsync : bus.i_vga_vsync;
  assign vsync_edge = vsync_act & ~vsync_q;

  // Next state: writer FSM first, then publish, then the vsync-time display swap.
  always_comb begin
    state_nx = state;
    rd_nx    = rd_bank;
    wr_nx    = wr_bank;
    rdy_nx   = rdy_bank;
    valid_nx = rdy_valid;
    drop_nx  = drop_cnt;
    abort_nx = abort_cnt;
    swap_nx  = 1'b0;
    publish  = 1'b0;

    case (state)
      ST_SYNC, ST_WAIT: begin
        if (bus.i_cam_frame_start) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        if (bus.i_cam_frame_done) begin
          publish  = 1'b1;
          state_nx = bus.i_cam_frame_start ? ST_WRITE : ST_WAIT;
        end else if (bus.i_cam_frame_start) begin
          abort_nx = abort_cnt + CNT_WIDTH'(1);
        end
      end
      default: state_nx = ST_SYNC;
    endcase

    if (publish) begin
      wr_nx    = rdy_bank;
      rdy_nx   = wr_bank;
      valid_nx = 1'b1;
      if (rdy_valid) drop_nx = drop_cnt + CNT_WIDTH'(1);
    end

    if (vsync_edge && valid_nx) begin
      rd_nx    = rdy_nx;
      rdy_nx   = rd_bank;
      valid_nx = 1'b0;
      swap_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_SYNC;
      rd_bank    <= 2'd0;
      wr_bank    <= 2'd1;
      rdy_bank   <= 2'd2;
      rdy_valid  <= 1'b0;
      vsync_q    <= 1'b1;
      swap_q     <= 1'b0;
      wr_allow_q <= 1'b0;
      wr_base_q  <= BASE_1;
      rd_base_q  <= '0;
      drop_cnt   <= '0;
      abort_cnt  <= '0;
    end else begin
      state      <= state_nx;
      rd_bank    <= rd_nx;
      wr_bank    <= wr_nx;
      rdy_bank   <= rdy_nx;
      rdy_valid  <= valid_nx;
      vsync_q    <= vsync_act;
      swap_q     <= swap_nx;
      wr_allow_q <= (state_nx == ST_WRITE);
      wr_base_q  <= base_of(wr_nx);
      rd_base_q  <= base_of(rd_nx);
      drop_cnt   <= drop_nx;
      abort_cnt  <= abort_nx;
    end
  end

  assign bus.o_wr_allow    = wr_allow_q;
  assign bus.o_wr_bank     = wr_bank;
  assign bus.o_rd_bank     = rd_bank;
  assign bus.o_wr_base     = wr_base_q;
  assign bus.o_rd_base     = rd_base_q;
  assign bus.o_frame_ready = rdy_valid;
  assign bus.o_swap        = swap_q;
  assign bus.o_drop_cnt    = drop_cnt;
  assign bus.o_abort_cnt   = abort_cnt;

endmodule

// File: tb/tb_fb_triple_buffer_scheduler.sv
// Bench for fb_triple_buffer_scheduler: directed scenarios with literal expectations plus
// randomized frame/vsync traffic checked every cycle against a bank-rotation model.
module tb_fb_triple_buffer_scheduler;
  localparam int unsigned AW    = 18;
  localparam int unsigned DEPTH = 76_800;
  localparam int unsigned CW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  fb_triple_buffer_scheduler_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  fb_triple_buffer_scheduler #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the three banks are just labels that rotate; the writer is either mid-frame or not.
  int          m_rd = 0, m_wr = 1, m_rdy = 2, tmp;
  bit          m_valid = 0, m_writing = 0, m_swap = 0, m_vs_prev = 1;
  logic [CW-1:0] m_drop = '0, m_abort = '0;

  always @(posedge clk or negedge rst_n) begin
    bit asserted, edge_now;
    if (!rst_n) begin
      m_rd = 0; m_wr = 1; m_rdy = 2; m_valid = 0; m_writing = 0;
      m_swap = 0; m_vs_prev = 1; m_drop = '0; m_abort = '0;
    end else begin
      asserted  = (bus.i_vga_vsync == 1'b0);
      edge_now  = asserted && !m_vs_prev;
      m_vs_prev = asserted;
      m_swap    = 0;
      if (m_writing && bus.i_cam_frame_done) begin
        if (m_valid) m_drop = m_drop + 1'b1;
        tmp = m_wr; m_wr = m_rdy; m_rdy = tmp;
        m_valid   = 1;
        m_writing = bus.i_cam_frame_start;
      end else if (bus.i_cam_frame_start) begin
        if (m_writing) m_abort = m_abort + 1'b1;
        m_writing = 1;
      end
      if (edge_now && m_valid) begin
        tmp = m_rd; m_rd = m_rdy; m_rdy = tmp;
        m_valid = 0;
        m_swap  = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("wr_allow", bus.o_wr_allow, m_writing);
    check("wr_bank", bus.o_wr_bank, m_wr);
    check("rd_bank", bus.o_rd_bank, m_rd);
    check("wr_base", bus.o_wr_base, longint'(m_wr) * DEPTH);
    check("rd_base", bus.o_rd_base, longint'(m_rd) * DEPTH);
    check("frame_ready", bus.o_frame_ready, m_valid);
    check("swap", bus.o_swap, m_swap);
    check("drop_cnt", bus.o_drop_cnt, m_drop);
    check("abort_cnt", bus.o_abort_cnt, m_abort);
    check("rd_ne_wr", (bus.o_rd_bank != bus.o_wr_bank), 1);
  end

  task automatic step(input logic s, input logic d, input logic vs);
    @(negedge clk);
    bus.i_cam_frame_start = s;
    bus.i_cam_frame_done  = d;
    bus.i_vga_vsync       = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_cam_frame_start = 1'b0;
    bus.i_cam_frame_done  = 1'b0;
    bus.i_vga_vsync       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.i_cam_frame_start = 1'b0;
    bus.i_cam_frame_done  = 1'b0;
    bus.i_vga_vsync       = 1'b1;
    do_reset();

    // Reset state
    check("rst_rd_bank", bus.o_rd_bank, 0);
    check("rst_wr_bank", bus.o_wr_bank, 1);
    check("rst_wr_base", bus.o_wr_base, 76_800);
    check("rst_rd_base", bus.o_rd_base, 0);
    check("rst_wr_allow", bus.o_wr_allow, 0);
    check("rst_ready", bus.o_frame_ready, 0);

    // Done before any start is ignored; then a full frame publishes
    step(0, 1, 1);
    check("early_done_ready", bus.o_frame_ready, 0);
    check("early_done_wr", bus.o_wr_bank, 1);
    step(1, 0, 1);
    check("start_allow", bus.o_wr_allow, 1);
    step(0, 1, 1);
    check("pub_wr_bank", bus.o_wr_bank, 2);
    check("pub_ready", bus.o_frame_ready, 1);
    check("pub_rd_bank", bus.o_rd_bank, 0);
    check("pub_wr_base", bus.o_wr_base, 153_600);
    check("pub_allow", bus.o_wr_allow, 0);

    // Vsync falling edge flips the display to the ready frame
    step(0, 0, 0);
    check("flip_rd_bank", bus.o_rd_bank, 1);
    check("flip_rd_base", bus.o_rd_base, 76_800);
    check("flip_swap", bus.o_swap, 1);
    check("flip_ready", bus.o_frame_ready, 0);
    step(0, 0, 0);
    check("flip_swap_once", bus.o_swap, 0);
    step(0, 0, 1);

    // Two frames without a vsync edge: second one drops the first
    do_reset();
    step(1, 0, 1); step(0, 1, 1);
    check("f1_wr_bank", bus.o_wr_bank, 2);
    step(1, 0, 1); step(0, 1, 1);
    check("f2_wr_bank", bus.o_wr_bank, 1);
    check("f2_drop", bus.o_drop_cnt, 1);
    check("f2_rd_bank", bus.o_rd_bank, 0);

    // Publish and vsync edge together from the reset banks
    do_reset();
    step(1, 0, 1);
    step(0, 1, 0);
    check("sim_rd_bank", bus.o_rd_bank, 1);
    check("sim_wr_bank", bus.o_wr_bank, 2);
    check("sim_swap", bus.o_swap, 1);
    check("sim_drop", bus.o_drop_cnt, 0);
    check("sim_ready", bus.o_frame_ready, 0);
    step(0, 0, 1);

    // Restart without done counts an abort
    do_reset();
    step(1, 0, 1); step(1, 0, 1);
    check("abort_cnt_lit", bus.o_abort_cnt, 1);
    check("abort_wr_bank", bus.o_wr_bank, 1);
    check("abort_allow", bus.o_wr_allow, 1);
    check("abort_ready", bus.o_frame_ready, 0);

    // Asynchronous reset mid-frame with vsync held asserted
    do_reset();
    step(1, 0, 1); step(0, 1, 1); step(1, 0, 1);
    check("pre_rst_ready", bus.o_frame_ready, 1);
    #1;
    rst_n = 1'b0;
    bus.i_cam_frame_start = 1'b0;
    bus.i_vga_vsync = 1'b0;
    #1;
    check("arst_allow", bus.o_wr_allow, 0);
    check("arst_ready", bus.o_frame_ready, 0);
    check("arst_wr_bank", bus.o_wr_bank, 1);
    check("arst_wr_base", bus.o_wr_base, 76_800);
    check("arst_rd_bank", bus.o_rd_bank, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      check("post_rst_noswap", bus.o_swap, 0);
    end

    // Randomized traffic; model compare runs every cycle
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.i_cam_frame_start = ($urandom % 7 == 0);
      bus.i_cam_frame_done  = ($urandom % 5 == 0);
      if ($urandom % 9 == 0) bus.i_vga_vsync = ~bus.i_vga_vsync;
    end
    @(negedge clk);
    bus.i_cam_frame_start = 1'b0;
    bus.i_cam_frame_done  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_triple_buffer_scheduler.md
Name: fb_triple_buffer_scheduler

Overview:
- Schedules three frame-buffer banks in one BRAM between the camera writer and the VGA reader using triple buffering.
- Camera always writes a bank the display is not reading. The display switches to the newest complete frame only at the start of the VGA vertical sync pulse, so frames never tear.
- Outputs are the bank indices and base addresses. The writer and reader add these to their local pixel address (0..DEPTH-1).

Parameters:
- ADDR_WIDTH, 18, width of full BRAM address (3*DEPTH must fit).
- DEPTH, 76_800, words per frame bank (320x240, 12-bit pixels).
- CNT_WIDTH, 16, width of the statistics counters.
- VSYNC_ACTIVE_LOW, 1, 1 = i_vga_vsync is asserted low; 0 = asserted high.

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_cam_frame_start  in  1  one-cycle pulse: camera frame begins.
- i_cam_frame_done  in  1  one-cycle pulse: last pixel of camera frame written.
- i_vga_vsync  in  1  VGA vertical sync level, synchronous to clk.
- o_wr_allow  out  1  camera writer may issue BRAM writes.
- o_wr_bank  out  2  bank being written (0..2).
- o_rd_bank  out  2  bank being displayed (0..2).
- o_wr_base  out  ADDR_WIDTH  o_wr_bank*DEPTH.
- o_rd_base  out  ADDR_WIDTH  o_rd_bank*DEPTH.
- o_frame_ready  out  1  a complete, undisplayed frame is held in the ready bank.
- o_swap  out  1  one-cycle pulse when o_rd_bank changes.
- o_drop_cnt  out  CNT_WIDTH  completed frames overwritten before display.
- o_abort_cnt  out  CNT_WIDTH  camera frames restarted without a done pulse.

Behaviour:
- Registers
  - rd_bank, wr_bank, rdy_bank (always a permutation of {0,1,2}), rdy_valid.
  - Write FSM state.
  - vsync_q: previous asserted-level of vsync.
- Reset values
  - rd_bank=0, wr_bank=1, rdy_bank=2, rdy_valid=0.
  - o_wr_base=DEPTH, o_rd_base=0.
  - o_wr_allow=0, o_frame_ready=0, o_swap=0, both counters 0.
  - FSM=SYNC; vsync_q=asserted, so there is no spurious edge after reset.
- Output timing
  - All outputs are registered and update on the clock edge that samples the event (one-cycle latency).
  - Base addresses are computed from the next bank value so they stay coherent with the bank outputs. Use a constant select, not a multiplier.
- Write FSM
  - SYNC: o_wr_allow=0. Goes to WRITE on i_cam_frame_start. i_cam_frame_done is ignored.
  - WRITE: o_wr_allow=1.
    - i_cam_frame_done: publish, then go to WAIT.
    - i_cam_frame_start with no done: o_abort_cnt+1, stay in WRITE on the same bank, no publish.
  - WAIT: o_wr_allow=0. Goes to WRITE on i_cam_frame_start. A done pulse in WAIT is ignored.
  - Start and done in the same cycle in WRITE: done wins (publish, go to WAIT), then start is applied, so the FSM ends in WRITE on the new wr_bank. No abort is counted.
- Publish
  - Swap wr_bank and rdy_bank, then set rdy_valid=1.
  - If rdy_valid was already 1, o_drop_cnt+1.
- VGA swap
  - vsync_edge = vsync asserted now and vsync_q not asserted.
  - On vsync_edge with rdy_valid=1 (after any same-cycle publish): swap rd_bank and rdy_bank, clear rdy_valid, and pulse o_swap.
  - On vsync_edge with rdy_valid=0: nothing changes and o_swap stays 0. The display repeats its frame.
- Simultaneous publish and vsync_edge
  - Publish applies first, then the swap.
  - Result: rd=old wr, rdy=old rd, wr=old rdy, rdy_valid=0, o_swap=1.
  - o_drop_cnt still increments if the old rdy_valid was 1.
- Invariants and counters
  - rd_bank never equals wr_bank.
  - Counters wrap modulo 2^CNT_WIDTH.
  - o_frame_ready mirrors rdy_valid.
- Reset mid-frame: all state returns to reset values immediately; the camera must resynchronise via the next i_cam_frame_start.

Test Plan:
- After reset, pulse done then start, then done: the first done is ignored. The second done moves wr_bank to 2, sets rdy_bank=1 and o_frame_ready=1; rd_bank stays 0 and o_wr_base becomes 153_600.
- With a ready frame (rdy=1), drive a vsync falling edge → next cycle rd_bank=1, rdy_bank=0, o_rd_base=76_800, o_swap=1 for exactly one cycle, o_frame_ready=0.
- Two complete camera frames with no vsync edge → o_drop_cnt=1, rd_bank unchanged at 0, and wr_bank/rdy_bank toggle between 1 and 2.
- From the reset bank state with the FSM in WRITE, done and vsync edge in the same cycle with no ready frame → rd=1, rdy=0, wr=2, o_swap=1, o_drop_cnt=0.
- Start, then start again with no done → o_abort_cnt=1, wr_bank unchanged, o_wr_allow stays 1, o_frame_ready stays 0.
- Assert i_rst_n=0 asynchronously while in WRITE with a ready frame → outputs return to reset values before the next clock edge; vsync held asserted through reset produces no o_swap after release.
